// File: rtl/alu.sv
// ARM datapath ALU: ADD/SUB/AND/ORR with NZCV flags.
// Define ALU_OUT_REG_EN to register the result and flags for pipelined builds.
module alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [1:0]       ALUControl,
   output logic [WIDTH-1:0] ALUResult,
   output logic [3:0]       ALUFlags
);

   logic [WIDTH-1:0] bop;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic [3:0]       flg;
   logic             arith;

   // SUB reuses the adder as A + ~B + 1
   assign bop   = ALUControl[0] ? ~SrcB : SrcB;
   assign sum   = {1'b0, SrcA} + {1'b0, bop}
                + {{WIDTH{1'b0}}, ALUControl[0]};
   assign arith = ~ALUControl[1];

   always_comb begin
      res = '0;
      case (ALUControl)
         2'b00:   res = sum[WIDTH-1:0];
         2'b01:   res = sum[WIDTH-1:0];
         2'b10:   res = SrcA & SrcB;
         2'b11:   res = SrcA | SrcB;
         default: res = '0;
      endcase
   end

   always_comb begin
      flg    = 4'b0000;
      flg[3] = res[WIDTH-1];
      flg[2] = (res == '0);
      flg[1] = arith & sum[WIDTH];
      flg[0] = arith
             & ~(SrcA[WIDTH-1] ^ SrcB[WIDTH-1] ^ ALUControl[0])
             & (SrcA[WIDTH-1] ^ sum[WIDTH-1]);
   end

`ifdef ALU_OUT_REG_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ALUResult <= '0;
         ALUFlags  <= 4'b0000;
      end else begin
         ALUResult <= res;
         ALUFlags  <= flg;
      end
   end
`else
   logic unused_clkrst;
   assign unused_clkrst = clk ^ reset;

   assign ALUResult = res;
   assign ALUFlags  = flg;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu; covers both the combinational
// and the ALU_OUT_REG_EN registered build.
module tb_alu;

   typedef struct {
      logic [31:0] r;
      logic [3:0]  f;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] SrcA, SrcB;
   logic [1:0]  ALUControl;
   logic [31:0] ALUResult;
   logic [3:0]  ALUFlags;

   exp_t sb[$];
   int   npass = 0;
   int   ntot  = 0;

   alu #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUControl (ALUControl),
      .ALUResult  (ALUResult),
      .ALUFlags   (ALUFlags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      ntot++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         npass++;
   endtask

   function automatic exp_t model(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [1:0] op,
                                  input string tag);
      exp_t e;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         2'd0: begin
            e.r = a + b;
            c = ({1'b0, a} + {1'b0, b}) > 33'hFFFF_FFFF;
            v = (a[31] == b[31]) && (e.r[31] != a[31]);
         end
         2'd1: begin
            e.r = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (e.r[31] != a[31]);
         end
         2'd2: e.r = a & b;
         default: e.r = a | b;
      endcase
      e.f = {e.r[31], e.r == 32'd0, c, v};
      e.tag = tag;
      return e;
   endfunction

   task automatic apply(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [1:0] op,
                        input string tag);
      exp_t e;
      @(negedge clk);
      SrcA = a;
      SrcB = b;
      ALUControl = op;
      sb.push_back(model(a, b, op, tag));
`ifdef ALU_OUT_REG_EN
      @(posedge clk);
`endif
      #1;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_res"}, ALUResult, e.r);
         chk({e.tag, "_flg"}, {28'd0, ALUFlags}, {28'd0, e.f});
      end
   endtask

   initial begin
      reset = 1'b1;
      SrcA = 32'd0;
      SrcB = 32'd0;
      ALUControl = 2'b00;
`ifdef ALU_OUT_REG_EN
      SrcA = 32'h1234_5678;
      SrcB = 32'h0000_0001;
      #1;
      chk("rst_res", ALUResult, 32'd0);
      chk("rst_flg", {28'd0, ALUFlags}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_res", ALUResult, 32'd0);
      @(negedge clk);
      reset = 1'b0;
`else
      #1;
      chk("rst_nofx_res", ALUResult, 32'd0);
      chk("rst_nofx_flg", {28'd0, ALUFlags}, 32'd4);
      reset = 1'b0;
`endif
      apply(32'd2, 32'd1, 2'b01, "sub_2_1");
      apply(32'd5, 32'd3, 2'b01, "sub_5_3");
      apply(32'd3, 32'd5, 2'b01, "sub_3_5");
      apply(32'd5, 32'd5, 2'b01, "sub_5_5");
      apply(32'd3, 32'd5, 2'b11, "orr_3_5");
      apply(32'h7FFF_FFFF, 32'd1, 2'b00, "add_ovf");
      apply(32'hFFFF_FFFF, 32'd1, 2'b00, "add_wrap");
      apply(32'h0000_00F0, 32'h0000_000F, 2'b10, "and_zero");
      apply(32'h8000_0000, 32'd1, 2'b01, "sub_ovf");
      apply(32'h8000_0000, 32'h8000_0000, 2'b00, "add_negovf");
      apply(32'hF0F0_0000, 32'hFFFF_0000, 2'b10, "and_neg");

      // spot known constants independent of the model
      @(negedge clk);
      SrcA = 32'd3;
      SrcB = 32'd5;
      ALUControl = 2'b01;
`ifdef ALU_OUT_REG_EN
      @(posedge clk);
`endif
      #1;
      chk("const_sub_res", ALUResult, 32'hFFFF_FFFE);
      chk("const_sub_flg", {28'd0, ALUFlags}, 32'h8);

`ifdef ALU_OUT_REG_EN
      apply(32'd3, 32'd5, 2'b11, "pre_rst");
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("async_rst_res", ALUResult, 32'd0);
      chk("async_rst_flg", {28'd0, ALUFlags}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_held_res", ALUResult, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      apply(32'd2, 32'd1, 2'b01, "post_rst");
`else
      @(negedge clk);
      reset = 1'b1;
      apply(32'd7, 32'd9, 2'b00, "rst_ignored");
      reset = 1'b0;
`endif

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         logic [1:0]  op;
         a  = $urandom;
         b  = $urandom;
         op = 2'($urandom_range(0, 3));
         if (i % 8 == 0) b = a;
         if (i % 8 == 1) a = 32'h8000_0000;
         apply(a, b, op, $sformatf("rnd%0d", i));
      end

      chk("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
